// File: rtl/ps2_kb_fifo_port.sv
// PS/2 keyboard controller for the processor port bus.
// Synchronises and filters the PS/2 pins, receives 11-bit frames, decodes E0/F0
// prefixes into {ext, brk, code} events and queues them in a FIFO that the
// processor reads through three ports starting at BASE_ADDR.
// Optional feature macro: KB_IRQ_EN adds a registered Interrupt output.
module ps2_kb_fifo_port #(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter int unsigned FIFO_AW        = 4,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Port_ID,
  input  logic       Read_Strobe,
  output logic [7:0] Keyboard_Output,
  input  logic       PS2_Clock,
  input  logic       PS2_Data
`ifdef KB_IRQ_EN
  ,
  output logic       Interrupt
`endif
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned PtrW  = FIFO_AW + 1;
  localparam int unsigned FltW  = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  AddrData  = BASE_ADDR + 8'd1;
  localparam logic [7:0]  AddrFlags = BASE_ADDR + 8'd2;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_st_e;

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_f_q, clk_f_d, clk_f_prev_q;
  logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      sr_q, sr_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            clk_s, data_s, fall, frame_done, frame_ok;
  logic [10:0]     frame;
  logic [7:0]      rx_byte;

  dec_st_e         st_q;
  logic            push_q, perr_set_q;
  logic [9:0]      push_data_q;

  logic [9:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic            ovf_q, ovf_d, perr_q, perr_d;
  logic            empty, full, pop, push_ok, ovf_set, rd_status;
  logic [9:0]      head;
  logic [3:0]      cnt_sat;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  // Filtered clock's falling edge is the bit sample point.
  assign fall   = clk_f_prev_q & ~clk_f_q;

  // Two-flop synchronisers; pins idle high so reset to 1 avoids a false edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2_Clock};
      data_sync_q <= {data_sync_q[0], PS2_Data};
    end
  end

  // Accept a new clock level only after it differs for FILTER_LEN cycles.
  always_comb begin
    clk_f_d   = clk_f_q;
    flt_cnt_d = '0;
    if (clk_s != clk_f_q) begin
      if (32'(flt_cnt_q) >= FILTER_LEN - 1) clk_f_d = clk_s;
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  // Frame shift register, bit counter and mid-frame idle timeout.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    to_cnt_d   = '0;
    frame_done = 1'b0;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d  = '0;
        frame_done = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        sr_d      = {data_s, sr_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (32'(to_cnt_q) >= TIMEOUT_CYCLES - 1) bit_cnt_d = '0;
      else                                     to_cnt_d  = to_cnt_q + 1'b1;
    end
  end

  // The stop bit is the live data sample; the other ten bits are in sr_q.
  assign frame    = {data_s, sr_q};
  assign rx_byte  = frame[8:1];
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  // Receiver state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      flt_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      to_cnt_q     <= '0;
    end else begin
      clk_f_q      <= clk_f_d;
      clk_f_prev_q <= clk_f_q;
      flt_cnt_q    <= flt_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Prefix decoder; bad frames only raise PERR and leave the state alone.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q        <= StIdle;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_set_q  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      perr_set_q <= 1'b0;
      if (frame_done) begin
        if (!frame_ok) begin
          perr_set_q <= 1'b1;
        end else if (rx_byte == 8'hE0) begin
          if (st_q == StIdle)     st_q <= StExt;
          else if (st_q == StBrk) st_q <= StExtBrk;
        end else if (rx_byte == 8'hF0) begin
          if (st_q == StIdle)     st_q <= StBrk;
          else if (st_q == StExt) st_q <= StExtBrk;
        end else begin
          push_q      <= 1'b1;
          push_data_q <= {(st_q == StExt) || (st_q == StExtBrk),
                          (st_q == StBrk) || (st_q == StExtBrk), rx_byte};
          st_q        <= StIdle;
        end
      end
    end
  end

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign pop       = Read_Strobe && (Port_ID == AddrData) && !empty;
  assign push_ok   = push_q && (!full || pop);
  assign ovf_set   = push_q && full && !pop;
  assign rd_status = Read_Strobe && (Port_ID == BASE_ADDR);
  assign cnt_sat   = (32'(count) > 32'd15) ? 4'hF : 4'(count);

  // FIFO pointers and sticky flags; a set on the clearing read wins.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_set    ? 1'b1 : (rd_status ? 1'b0 : ovf_q);
    perr_d   = perr_set_q ? 1'b1 : (rd_status ? 1'b0 : perr_q);
  end

  // FIFO storage and flag registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  // Register window read mux.
  always_comb begin
    Keyboard_Output = 8'h00;
    if (Port_ID == BASE_ADDR) begin
      Keyboard_Output = {cnt_sat, perr_q, ovf_q, full, ~empty};
    end else if (Port_ID == AddrData) begin
      Keyboard_Output = empty ? 8'h00 : head[7:0];
    end else if (Port_ID == AddrFlags) begin
      Keyboard_Output = empty ? 8'h00 : {6'b0, head[9], head[8]};
    end
  end

`ifdef KB_IRQ_EN
  logic irq_q;

  // Level interrupt, one cycle behind the pending condition.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq_q <= 1'b0;
    else       irq_q <= ~empty | ovf_q | perr_q;
  end

  assign Interrupt = irq_q;
`endif

endmodule
